// File: rtl/tbman_pkg.sv
// Shared constants for the testbench manager: register map, STATUS layout,
// PLATFORM bit meanings and an address-to-word helper.
package tbman_pkg;

  // Register byte offsets (word access only)
  localparam logic [15:0] ADDR_PRINT0    = 16'h0000;
  localparam logic [15:0] ADDR_STATUS    = 16'h0040;
  localparam logic [15:0] ADDR_EXIT      = 16'h0044;
  localparam logic [15:0] ADDR_PLATFORM  = 16'h0048;
  localparam logic [15:0] ADDR_CYCLE_LO  = 16'h004C;
  localparam logic [15:0] ADDR_CYCLE_HI  = 16'h0050;
  localparam logic [15:0] ADDR_IRQ_FORCE = 16'h0054;

  // STATUS field base bit positions
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 8;
  localparam int ST_OVF   = 16;
  localparam int ST_HALT  = 24;

  // PLATFORM register bit meanings
  localparam int PLAT_SIM  = 0;
  localparam int PLAT_FPGA = 1;

  // Byte address to word index; the low two address bits are ignored.
  function automatic logic [13:0] word_of(input logic [15:0] a);
    return a[15:2];
  endfunction

endpackage

// File: rtl/tbman_fifo.sv
// Synchronous FIFO with count-based full/empty. A push while full is
// accepted when a pop happens in the same cycle. Head is combinational.
module tbman_fifo
  import tbman_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next-state: storage write, pointer advance, occupancy update
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State register; reset discards contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tbman_native.sv
// Testbench manager: NCHAN print FIFOs drained round-robin onto a
// valid/ready character stream, plus exit/halt, 64-bit cycle counter with
// atomic hi/lo readback, platform ID and forced IRQ lines.
//
// Character stream handshake: a character transfers on every rising edge
// where out_valid && out_ready. While out_valid && !out_ready, out_chan and
// out_data hold steady: the granted channel is latched and newly non-empty
// channels cannot preempt it.
module tbman_native
  import tbman_pkg::*;
#(
  parameter int          NCHAN    = 4,
  parameter int          DEPTH    = 16,
  parameter int          NIRQ     = 1,
  parameter logic [31:0] PLATFORM = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tbman_sel,
  input  logic            tbman_write,
  input  logic [15:0]     tbman_addr,
  input  logic [31:0]     tbman_wdata,
  output logic [31:0]     tbman_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_chan,
  output logic [7:0]      out_data,
  output logic            halt,
  output logic [31:0]     exit_code,
  output logic [NIRQ-1:0] irq_force
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int GW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [13:0]      word;
  logic             rd, wr, hs;
  logic [NCHAN-1:0] push_req, pop, empty, full, ovf_set, ovf_clr;
  logic [7:0]       head [NCHAN];
  logic [CW-1:0]    cnt  [NCHAN];
  logic [GW-1:0]    grant, cand;
  logic [GW:0]      sum;
  logic             found;
  logic             unused_addr;

  logic [NCHAN-1:0] ovf_q, ovf_d;
  logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [GW-1:0]    lock_chan_q, lock_chan_d;
  logic             halt_q, halt_d;
  logic [31:0]      exit_q, exit_d;
  logic [NIRQ-1:0]  irq_q, irq_d;
  logic [63:0]      counter_q, counter_d;
  logic [31:0]      hi_q, hi_d;

  assign word        = word_of(tbman_addr);
  assign unused_addr = ^tbman_addr[1:0];
  assign rd          = tbman_sel && !tbman_write;
  assign wr          = tbman_sel && tbman_write;
  assign hs          = out_valid && out_ready;

  genvar c;
  generate
    for (c = 0; c < NCHAN; c++) begin : g_chan
      assign push_req[c] = wr && (word == 14'(c));
      assign pop[c]      = hs && (grant == GW'(c));
      assign ovf_set[c]  = push_req[c] && full[c] && !pop[c];
      tbman_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req[c]),
        .wdata (tbman_wdata[7:0]),
        .pop   (pop[c]),
        .head  (head[c]),
        .count (cnt[c]),
        .empty (empty[c]),
        .full  (full[c])
      );
    end
  endgenerate

  // Grant: latched channel while stalled, else first non-empty at/after rr_ptr
  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NCHAN; i++) begin
      sum = {1'b0, rr_ptr_q} + (GW+1)'(i);
      if (sum >= (GW+1)'(NCHAN)) sum = sum - (GW+1)'(NCHAN);
      cand = sum[GW-1:0];
      if (!found && !empty[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
    if (lock_q) grant = lock_chan_q;
  end

  assign out_valid = ~&empty;
  assign out_chan  = out_valid ? 3'(grant) : 3'd0;
  assign out_data  = out_valid ? head[grant] : 8'h00;
  assign halt      = halt_q;
  assign exit_code = exit_q;
  assign irq_force = irq_q;

  // Register read mux; zero when idle, writing, or unmapped
  always_comb begin
    tbman_rdata = '0;
    if (rd) begin
      for (int i = 0; i < NCHAN; i++) begin
        if (word == 14'(i)) tbman_rdata = 32'(cnt[i]);
      end
      if (word == word_of(ADDR_STATUS)) begin
        tbman_rdata[ST_EMPTY +: NCHAN] = empty;
        tbman_rdata[ST_FULL  +: NCHAN] = full;
        tbman_rdata[ST_OVF   +: NCHAN] = ovf_q;
        tbman_rdata[ST_HALT]           = halt_q;
      end
      if (word == word_of(ADDR_EXIT))      tbman_rdata = exit_q;
      if (word == word_of(ADDR_PLATFORM))  tbman_rdata = PLATFORM;
      if (word == word_of(ADDR_CYCLE_LO))  tbman_rdata = counter_q[31:0];
      if (word == word_of(ADDR_CYCLE_HI))  tbman_rdata = hi_q;
      if (word == word_of(ADDR_IRQ_FORCE)) tbman_rdata = 32'(irq_q);
    end
  end

  // Next-state for arbiter, control registers and cycle counter
  always_comb begin
    ovf_clr     = (wr && word == word_of(ADDR_STATUS)) ? tbman_wdata[ST_OVF +: NCHAN] : '0;
    ovf_d       = (ovf_q & ~ovf_clr) | ovf_set;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = out_valid && !out_ready;
    lock_chan_d = grant;
    halt_d      = halt_q;
    exit_d      = exit_q;
    irq_d       = irq_q;
    counter_d   = counter_q + 64'd1;
    hi_d        = hi_q;
    if (hs) rr_ptr_d = (int'(grant) == NCHAN - 1) ? '0 : grant + GW'(1);
    if (wr && word == word_of(ADDR_EXIT) && !halt_q) begin
      halt_d = 1'b1;
      exit_d = tbman_wdata;
    end
    if (wr && word == word_of(ADDR_IRQ_FORCE)) irq_d = tbman_wdata[NIRQ-1:0];
    if (rd && word == word_of(ADDR_CYCLE_LO))  hi_d  = counter_q[63:32];
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q       <= '0;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_chan_q <= '0;
      halt_q      <= 1'b0;
      exit_q      <= '0;
      irq_q       <= '0;
      counter_q   <= '0;
      hi_q        <= '0;
    end else begin
      ovf_q       <= ovf_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_chan_q <= lock_chan_d;
      halt_q      <= halt_d;
      exit_q      <= exit_d;
      irq_q       <= irq_d;
      counter_q   <= counter_d;
      hi_q        <= hi_d;
    end
  end

endmodule

// File: tb/tb_tbman_native.sv
// Directed bench for tbman_native (NCHAN=4, DEPTH=16, NIRQ=1, PLATFORM=1).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or 1ns after an input change for combinational read data.
module tb_tbman_native;

  logic        clk = 1'b0;
  logic        rst;
  logic        tbman_sel, tbman_write, out_ready;
  logic [15:0] tbman_addr;
  logic [31:0] tbman_wdata, tbman_rdata;
  logic        out_valid, halt;
  logic [2:0]  out_chan;
  logic [7:0]  out_data;
  logic [31:0] exit_code;
  logic [0:0]  irq_force;
  logic [63:0] tb_cyc;
  logic [31:0] r, exp_lo;
  logic [7:0]  exp_c;
  int          checks = 0;
  int          failures = 0;

  tbman_native #(.NCHAN(4), .DEPTH(16), .NIRQ(1), .PLATFORM(32'h1)) dut (
    .clk(clk), .rst(rst), .tbman_sel(tbman_sel), .tbman_write(tbman_write),
    .tbman_addr(tbman_addr), .tbman_wdata(tbman_wdata), .tbman_rdata(tbman_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_data(out_data), .halt(halt), .exit_code(exit_code), .irq_force(irq_force)
  );

  // Clock and independent cycle reference
  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cyc <= 64'd0;
    else     tb_cyc <= tb_cyc + 64'd1;
  end

  // Drivers: called on a falling edge, return on the next falling edge
  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    tbman_sel = 1'b1; tbman_write = 1'b1; tbman_addr = a; tbman_wdata = d;
    @(negedge clk);
    tbman_sel = 1'b0; tbman_write = 1'b0; tbman_addr = '0; tbman_wdata = '0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    tbman_sel = 1'b1; tbman_write = 1'b0; tbman_addr = a;
    #1 d = tbman_rdata;
    @(negedge clk);
    tbman_sel = 1'b0; tbman_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tbman_sel = 0; tbman_write = 0; tbman_addr = '0; tbman_wdata = '0; out_ready = 0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_chan !== 3'd0 || out_data !== 8'h00) begin failures++; $display("FAIL reset_out got=%0d/%h exp=0/00", out_chan, out_data); end
    checks++; if (halt !== 1'b0 || exit_code !== 32'h0 || irq_force !== 1'b0) begin failures++; $display("FAIL reset_ctl got=%b/%h/%b exp=0/0/0", halt, exit_code, irq_force); end
    checks++; if (tbman_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", tbman_rdata); end
    rst = 1'b0;
    bus_read(16'h0040, r);
    checks++; if (r !== 32'h0000000F) begin failures++; $display("FAIL reset_status got=%h exp=0000000f", r); end
    bus_read(16'h0050, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", r); end
  endtask

  task automatic test_print();
    out_ready = 1'b1;
    bus_write(16'h0000, 32'h48);
    checks++; if (out_valid !== 1'b1 || out_chan !== 3'd0 || out_data !== 8'h48) begin failures++; $display("FAIL print_h got=%b/%0d/%h exp=1/0/48", out_valid, out_chan, out_data); end
    bus_write(16'h0000, 32'h69);
    checks++; if (out_valid !== 1'b1 || out_chan !== 3'd0 || out_data !== 8'h69) begin failures++; $display("FAIL print_i got=%b/%0d/%h exp=1/0/69", out_valid, out_chan, out_data); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL print_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) bus_write(16'h0004, 32'h30 + 32'(i));
    bus_read(16'h0040, r);
    checks++; if (r !== 32'h0002020D) begin failures++; $display("FAIL ovf_status got=%h exp=0002020d", r); end
    bus_read(16'h0004, r);
    checks++; if (r !== 32'h10) begin failures++; $display("FAIL ovf_count got=%h exp=10", r); end
    bus_write(16'h0040, 32'h00020000);
    bus_read(16'h0040, r);
    checks++; if (r !== 32'h0000020D) begin failures++; $display("FAIL ovf_clear got=%h exp=0000020d", r); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_c = 8'h30 + 8'(i);
      checks++; if (out_valid !== 1'b1 || out_chan !== 3'd1 || out_data !== exp_c) begin failures++; $display("FAIL ovf_drain%0d got=%b/%0d/%h exp=1/1/%h", i, out_valid, out_chan, out_data, exp_c); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) bus_write(16'h000C, 32'h40 + 32'(i));
    out_ready = 1'b1;
    bus_write(16'h000C, 32'h7F);
    out_ready = 1'b0;
    bus_read(16'h0040, r);
    checks++; if (r !== 32'h00000807) begin failures++; $display("FAIL fullpop_status got=%h exp=00000807", r); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_c = (i == 15) ? 8'h7F : 8'h41 + 8'(i);
      checks++; if (out_chan !== 3'd3 || out_data !== exp_c) begin failures++; $display("FAIL fullpop_drain%0d got=%0d/%h exp=3/%h", i, out_chan, out_data, exp_c); end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [4];
    logic [2:0] exp_ch [4];
    exp_d  = '{8'h41, 8'h78, 8'h42, 8'h79};
    exp_ch = '{3'd0, 3'd2, 3'd0, 3'd2};
    out_ready = 1'b0;
    bus_write(16'h0000, 32'h41);
    bus_write(16'h0000, 32'h42);
    bus_write(16'h0008, 32'h78);
    bus_write(16'h0008, 32'h79);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_chan !== exp_ch[i] || out_data !== exp_d[i]) begin failures++; $display("FAIL rr%0d got=%b/%0d/%h exp=1/%0d/%h", i, out_valid, out_chan, out_data, exp_ch[i], exp_d[i]); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall_hold();
    out_ready = 1'b0;
    bus_write(16'h0004, 32'h31);
    checks++; if (out_chan !== 3'd1 || out_data !== 8'h31) begin failures++; $display("FAIL stall_first got=%0d/%h exp=1/31", out_chan, out_data); end
    bus_write(16'h000C, 32'h33);
    checks++; if (out_chan !== 3'd1 || out_data !== 8'h31) begin failures++; $display("FAIL stall_hold got=%0d/%h exp=1/31", out_chan, out_data); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_chan !== 3'd3 || out_data !== 8'h33) begin failures++; $display("FAIL stall_next got=%b/%0d/%h exp=1/3/33", out_valid, out_chan, out_data); end
    @(negedge clk);
  endtask

  task automatic test_exit();
    bus_write(16'h0044, 32'h0000002A);
    bus_write(16'h0044, 32'h00000005);
    checks++; if (halt !== 1'b1 || exit_code !== 32'h2A) begin failures++; $display("FAIL exit_latch got=%b/%h exp=1/0000002a", halt, exit_code); end
    bus_read(16'h0044, r);
    checks++; if (r !== 32'h2A) begin failures++; $display("FAIL exit_read got=%h exp=0000002a", r); end
    bus_read(16'h0040, r);
    checks++; if (r !== 32'h0100000F) begin failures++; $display("FAIL exit_status got=%h exp=0100000f", r); end
  endtask

  task automatic test_cycle();
    repeat (20) @(negedge clk);
    tbman_sel = 1'b1; tbman_write = 1'b0; tbman_addr = 16'h004C;
    #1 r = tbman_rdata; exp_lo = tb_cyc[31:0];
    @(negedge clk); tbman_sel = 1'b0;
    checks++; if (r !== exp_lo) begin failures++; $display("FAIL cycle_lo got=%h exp=%h", r, exp_lo); end
    bus_read(16'h0050, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL cycle_hi got=%h exp=0", r); end
    force dut.counter_q = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.counter_q;
    bus_read(16'h004C, r);
    checks++; if (r !== 32'hFFFFFFFE) begin failures++; $display("FAIL wrap_lo1 got=%h exp=fffffffe", r); end
    bus_read(16'h0050, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL wrap_hi1 got=%h exp=0", r); end
    bus_read(16'h004C, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL wrap_lo2 got=%h exp=0", r); end
    bus_read(16'h0050, r);
    checks++; if (r !== 32'h1) begin failures++; $display("FAIL wrap_hi2 got=%h exp=1", r); end
  endtask

  task automatic test_platform_irq();
    bus_read(16'h0048, r);
    checks++; if (r !== 32'h1) begin failures++; $display("FAIL platform got=%h exp=1", r); end
    bus_write(16'h0048, 32'hFF);
    bus_read(16'h0048, r);
    checks++; if (r !== 32'h1) begin failures++; $display("FAIL platform_ro got=%h exp=1", r); end
    tbman_sel = 1'b1; tbman_write = 1'b1; tbman_addr = 16'h0054; tbman_wdata = 32'hFFFFFFFF;
    #1 r = tbman_rdata;
    @(negedge clk); tbman_sel = 1'b0; tbman_write = 1'b0;
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL rdata_on_write got=%h exp=0", r); end
    checks++; if (irq_force !== 1'b1) begin failures++; $display("FAIL irq_out got=%b exp=1", irq_force); end
    bus_read(16'h0054, r);
    checks++; if (r !== 32'h1) begin failures++; $display("FAIL irq_read got=%h exp=1", r); end
    bus_read(16'h0060, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL unmapped got=%h exp=0", r); end
    bus_read(16'h0014, r);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL chan_range got=%h exp=0", r); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    bus_write(16'h0000, 32'h5A);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin failures++; $display("FAIL mid_pre got=%b/%h exp=1/5a", out_valid, out_data); end
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin failures++; $display("FAIL mid_async got=%b/%h exp=0/00", out_valid, out_data); end
    checks++; if (halt !== 1'b0 || exit_code !== 32'h0 || irq_force !== 1'b0) begin failures++; $display("FAIL mid_ctl got=%b/%h/%b exp=0/0/0", halt, exit_code, irq_force); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_discard got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_print();
    test_overflow();
    test_full_pop();
    test_round_robin();
    test_stall_hold();
    test_exit();
    test_cycle();
    test_platform_irq();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
